// File: rtl/alu_ctrl_seq.sv
// Registered Am2901-style ALU controller: valid/ready instruction intake, repeat counter, one-hot register
// selects, registered datapath controls and status. Define CTRL_STICKY_OVR_EN to add a sticky overflow flag.
module alu_ctrl_seq #(
    parameter int WIDTH  = 16,
    parameter int NREG   = 16,
    parameter int ADDR_W = 4,
    parameter int RPT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [8:0]        i,
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    input  logic [RPT_W-1:0]  rpt,
    input  logic [WIDTH-1:0]  f,
    input  logic [WIDTH-1:0]  c,
    input  logic [WIDTH-1:0]  p,
    input  logic              oe,
    input  logic [WIDTH-1:0]  y_data,
    inout  wire  [WIDTH-1:0]  y_tri,
    inout  wire               ram_lsb,
    inout  wire               ram_msb,
    inout  wire               q_lsb,
    inout  wire               q_msb,
    input  logic              q_lsb_data,
    input  logic              q_msb_data,
    output logic [NREG-1:0]   select_a_hi,
    output logic [NREG-1:0]   select_b_hi,
    output logic [1:0]        aluop,
    output logic [1:0]        r_sel,
    output logic [1:0]        s_sel,
    output logic              r_inv,
    output logic              s_inv,
    output logic [1:0]        ff_sel,
    output logic              q_en,
    output logic [1:0]        regf_sel,
    output logic              alu_dest,
    output logic              reg_wr,
    output logic              busy,
    output logic              g_lo,
    output logic              p_lo,
    output logic              ovr,
    output logic              z,
    output logic [3:0]        status
`ifdef CTRL_STICKY_OVR_EN
    ,
    input  logic              clr_sticky,
    output logic              ovr_sticky
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] r_sel;
        logic [1:0] s_sel;
        logic       r_inv;
        logic       s_inv;
        logic [1:0] ff_sel;
        logic       q_en;
        logic [1:0] regf_sel;
        logic       alu_dest;
        logic       reg_wr;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [8:0] ins);
        ctrl_t d;
        d.aluop    = {ins[5], ins[4] & (ins[3] | ins[5])};
        d.r_sel    = {(~ins[2] & ins[1]) | (ins[2] & ~ins[1] & ~ins[0]), ~ins[2] & ~ins[1]};
        d.s_sel    = {(ins[2] & ins[1]) | (~ins[2] & ~ins[0]), ins[0] & (~ins[2] | ins[1])};
        d.r_inv    = ins[3] & (~ins[4] | ins[5]);
        d.s_inv    = ~ins[5] & ins[4] & ~ins[3];
        d.ff_sel   = {ins[8] & ins[7] & ~ins[6], ~ins[8] & ~ins[7] & ~ins[6]};
        d.q_en     = (~ins[7] & ~ins[6]) | (ins[8] & ~ins[6]);
        d.regf_sel = {ins[8] & ins[7], ~ins[8] & ins[7]};
        d.alu_dest = ins[8] | ~ins[7] | ins[6];
        d.reg_wr   = ins[8] | ins[7];
        return d;
    endfunction

    // Addresses beyond the regfile depth select nothing.
    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] ad);
        logic [NREG-1:0] oh;
        for (int j = 0; j < NREG; j++) begin
            oh[j] = (ad == ADDR_W'(j));
        end
        return oh;
    endfunction

    state_t           state_q, state_d;
    logic [RPT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [NREG-1:0]  sel_a_q, sel_a_d;
    logic [NREG-1:0]  sel_b_q, sel_b_d;
    logic             shl_q, shl_d;
    logic             shr_q, shr_d;
    logic [3:0]       status_q, status_d;
    logic             accept;
    logic             exec;
`ifdef CTRL_STICKY_OVR_EN
    logic             ovr_sticky_q, ovr_sticky_d;
`endif

    assign exec        = (state_q == EXEC);
    assign instr_ready = !exec || (cnt_q == '0);
    assign accept      = instr_valid && instr_ready;

    assign z    = ~|f;
    assign ovr  = c[WIDTH-1] ^ c[WIDTH-2];
    assign g_lo = ~c[WIDTH-1];
    assign p_lo = ~&p;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;
        shl_d    = shl_q;
        shr_d    = shr_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                ctrl_d.reg_wr = 1'b0;
                ctrl_d.q_en   = 1'b0;
            end
            EXEC: begin
                status_d = {f[WIDTH-1], ovr, c[WIDTH-1], z};
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - RPT_W'(1);
                end else if (!accept) begin
                    state_d       = IDLE;
                    ctrl_d.reg_wr = 1'b0;
                    ctrl_d.q_en   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new instruction may be taken from IDLE or on the final repeat of the current one.
        if (accept) begin
            state_d = EXEC;
            cnt_d   = rpt;
            ctrl_d  = decode(i);
            sel_a_d = onehot(a);
            sel_b_d = onehot(b);
            shl_d   = i[8] & i[7];
            shr_d   = i[8] & ~i[7];
        end
    end

`ifdef CTRL_STICKY_OVR_EN
    always_comb begin
        ovr_sticky_d = ovr_sticky_q;
        if (clr_sticky) ovr_sticky_d = 1'b0;
        if (exec && ovr) ovr_sticky_d = 1'b1;
    end
    assign ovr_sticky = ovr_sticky_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ctrl_q       <= '0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            shl_q        <= 1'b0;
            shr_q        <= 1'b0;
            status_q     <= '0;
`ifdef CTRL_STICKY_OVR_EN
            ovr_sticky_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
            shl_q        <= shl_d;
            shr_q        <= shr_d;
            status_q     <= status_d;
`ifdef CTRL_STICKY_OVR_EN
            ovr_sticky_q <= ovr_sticky_d;
`endif
        end
    end

    assign busy        = exec;
    assign select_a_hi = sel_a_q;
    assign select_b_hi = sel_b_q;
    assign aluop       = ctrl_q.aluop;
    assign r_sel       = ctrl_q.r_sel;
    assign s_sel       = ctrl_q.s_sel;
    assign r_inv       = ctrl_q.r_inv;
    assign s_inv       = ctrl_q.s_inv;
    assign ff_sel      = ctrl_q.ff_sel;
    assign q_en        = ctrl_q.q_en;
    assign regf_sel    = ctrl_q.regf_sel;
    assign alu_dest    = ctrl_q.alu_dest;
    assign reg_wr      = ctrl_q.reg_wr;
    assign status      = status_q;

    // Shifter end bits are only driven while an up/down shift instruction is executing.
    assign ram_msb = (exec && shl_q) ? f[WIDTH-1] : 1'bz;
    assign q_msb   = (exec && shl_q) ? q_msb_data : 1'bz;
    assign ram_lsb = (exec && shr_q) ? f[0]       : 1'bz;
    assign q_lsb   = (exec && shr_q) ? q_lsb_data : 1'bz;
    assign y_tri   = oe ? y_data : {WIDTH{1'bz}};

endmodule
